// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731 codec configuration sequencer:
// FSM state encoding, register addresses and the default init-table data.
package wm8731_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_BUSY,
    WAIT_IDLE,
    GAP,
    DONE
  } state_t;

  localparam logic [6:0] R_LLIN   = 7'h00;
  localparam logic [6:0] R_RLIN   = 7'h01;
  localparam logic [6:0] R_LHP    = 7'h02;
  localparam logic [6:0] R_RHP    = 7'h03;
  localparam logic [6:0] R_AAPC   = 7'h04;
  localparam logic [6:0] R_DAPC   = 7'h05;
  localparam logic [6:0] R_PDC    = 7'h06;
  localparam logic [6:0] R_DAIF   = 7'h07;
  localparam logic [6:0] R_SC     = 7'h08;
  localparam logic [6:0] R_ACTIVE = 7'h09;
  localparam logic [6:0] R_RESET  = 7'h0F;

  localparam int NUM_CFG = 11;

  localparam logic [8:0] D_RESET  = 9'h000;
  localparam logic [8:0] D_LLIN   = 9'h017;
  localparam logic [8:0] D_RLIN   = 9'h017;
  localparam logic [8:0] D_LHP    = 9'h079;
  localparam logic [8:0] D_RHP    = 9'h079;
  localparam logic [8:0] D_AAPC   = 9'h012;
  localparam logic [8:0] D_DAPC   = 9'h000;
  localparam logic [8:0] D_PDC    = 9'h000;
  localparam logic [8:0] D_DAIF   = 9'h042;
  localparam logic [8:0] D_SC     = 9'h000;
  localparam logic [8:0] D_ACTIVE = 9'h001;

  // Out-of-range indices fall back to the codec reset word.
  localparam logic [15:0] ROM_DEFAULT = 16'h1E00;

  function automatic logic [15:0] cfg_word(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/wm8731_cfg_rom.sv
// Combinational init table: entry index -> {reg_addr[6:0], reg_data[8:0]}.
// ACTIVE is deliberately last so the codec only starts once fully configured.
module wm8731_cfg_rom
  import wm8731_pkg::*;
(
  input  logic [3:0]  index_i,
  output logic [15:0] word_o
);

  always_comb begin
    word_o = ROM_DEFAULT;
    case (index_i)
      4'd0:    word_o = cfg_word(R_RESET,  D_RESET);
      4'd1:    word_o = cfg_word(R_LLIN,   D_LLIN);
      4'd2:    word_o = cfg_word(R_RLIN,   D_RLIN);
      4'd3:    word_o = cfg_word(R_LHP,    D_LHP);
      4'd4:    word_o = cfg_word(R_RHP,    D_RHP);
      4'd5:    word_o = cfg_word(R_AAPC,   D_AAPC);
      4'd6:    word_o = cfg_word(R_DAPC,   D_DAPC);
      4'd7:    word_o = cfg_word(R_PDC,    D_PDC);
      4'd8:    word_o = cfg_word(R_DAIF,   D_DAIF);
      4'd9:    word_o = cfg_word(R_SC,     D_SC);
      4'd10:   word_o = cfg_word(R_ACTIVE, D_ACTIVE);
      default: word_o = ROM_DEFAULT;
    endcase
  end

endmodule

// File: rtl/wm8731_cfg_seq.sv
// WM8731 configuration sequencer: streams the init table to an I2C write
// controller, then serves single host register writes once init is done.
module wm8731_cfg_seq
  import wm8731_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR     = 8'h34,
  parameter int         GAP_CYCLES   = 1000,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        host_req,
  input  logic [6:0]  host_addr,
  input  logic [8:0]  host_data,
  output logic        host_ack,
  input  logic        i2c_idle,
  output logic [23:0] i2c_din,
  output logic        i2c_wr,
  output logic        busy,
  output logic        init_done,
  output logic        err,
  output logic [3:0]  cfg_index
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [3:0]      cfg_index_q, cfg_index_d;
  logic [23:0]     din_q, din_d;
  logic            host_mode_q, host_mode_d;
  logic            init_done_q, init_done_d;
  logic            err_q, err_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [15:0]     rom_word;

  wm8731_cfg_rom u_rom (
    .index_i (cfg_index_q),
    .word_o  (rom_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cfg_index_q <= '0;
      din_q       <= '0;
      host_mode_q <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      gap_cnt_q   <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cfg_index_q <= cfg_index_d;
      din_q       <= din_d;
      host_mode_q <= host_mode_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      gap_cnt_q   <= gap_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Counters self-clear whenever their owning state is not active.
  always_comb begin
    state_d     = state_q;
    cfg_index_d = cfg_index_q;
    din_d       = din_q;
    host_mode_d = host_mode_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    gap_cnt_d   = '0;
    to_cnt_d    = '0;
    case (state_q)
      IDLE: begin
        if (start && i2c_idle) begin
          state_d     = LOAD;
          cfg_index_d = '0;
          host_mode_d = 1'b0;
        end
      end
      LOAD: begin
        din_d   = host_mode_q ? {DEV_ADDR, host_addr, host_data} : {DEV_ADDR, rom_word};
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!i2c_idle) begin
          state_d = WAIT_IDLE;
        end else if (to_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (i2c_idle) state_d = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          if (host_mode_q) begin
            host_mode_d = 1'b0;
            state_d     = DONE;
          end else if (cfg_index_q == 4'(NUM_CFG - 1)) begin
            init_done_d = 1'b1;
            state_d     = DONE;
          end else begin
            cfg_index_d = cfg_index_q + 4'd1;
            state_d     = LOAD;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (host_req && i2c_idle) begin
          host_mode_d = 1'b1;
          state_d     = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign i2c_wr    = (state_q == ISSUE);
  assign host_ack  = (state_q == ISSUE) && host_mode_q;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign i2c_din   = din_q;
  assign cfg_index = cfg_index_q;
  assign init_done = init_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Bench for wm8731_cfg_seq: I2C responder model, write monitor and
// scenario tasks checked against a table-driven expected word list.
module tb_wm8731_cfg_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        host_req = 1'b0;
  logic [6:0]  host_addr = '0;
  logic [8:0]  host_data = '0;
  logic        i2c_idle = 1'b1;
  logic        host_ack;
  logic [23:0] i2c_din;
  logic        i2c_wr;
  logic        busy;
  logic        init_done;
  logic        err;
  logic [3:0]  cfg_index;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_len = 50;
  logic        skip_en = 1'b0;
  logic [23:0] skip_word = '0;
  logic [23:0] wr_words[$];
  int          wr_times[$];
  int          ack_cnt = 0;

  int tbl_a [11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int tbl_d [11] = '{0, 'h17, 'h17, 'h79, 'h79, 'h12, 0, 0, 'h42, 0, 1};

  localparam int MIN_SPACING = 1000 + 2 + 50 + 3;

  wm8731_cfg_seq #(
    .DEV_ADDR     (8'h34),
    .GAP_CYCLES   (1000),
    .BUSY_TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .host_req  (host_req),
    .host_addr (host_addr),
    .host_data (host_data),
    .host_ack  (host_ack),
    .i2c_idle  (i2c_idle),
    .i2c_din   (i2c_din),
    .i2c_wr    (i2c_wr),
    .busy      (busy),
    .init_done (init_done),
    .err       (err),
    .cfg_index (cfg_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (i2c_wr) begin
      wr_words.push_back(i2c_din);
      wr_times.push_back(cyc);
    end
    if (host_ack) ack_cnt <= ack_cnt + 1;
  end

  // I2C controller model: goes busy a little after each strobe, for resp_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (i2c_wr && !reset && !(skip_en && i2c_din == skip_word)) begin
        repeat (3) @(negedge clk);
        if (!reset) begin
          i2c_idle = 1'b0;
          for (int k = 0; k < resp_len && !reset; k++) @(negedge clk);
          i2c_idle = 1'b1;
        end
      end
    end
  end

  function automatic logic [23:0] word_of(int dev, int a, int d);
    return 24'(dev * 65536 + a * 512 + d);
  endfunction

  function automatic logic [23:0] exp_word(int i);
    return word_of(8'h34, tbl_a[i], tbl_d[i]);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; host_req = 1'b0; skip_en = 1'b0; resp_len = 50;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (init_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_word(input logic [23:0] w, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (i2c_wr && i2c_din == w) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_not_busy(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({i2c_wr, host_ack, busy, init_done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {i2c_wr, host_ack, busy, init_done, err});
    end
    checks++;
    if (cfg_index !== 4'd0) begin errors++; $display("FAIL reset_index got %0d want 0", cfg_index); end
    checks++;
    if (i2c_din !== 24'h0) begin errors++; $display("FAIL reset_din got %h want 000000", i2c_din); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || i2c_wr !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b wr=%b want 0 0", busy, i2c_wr);
    end
  endtask

  task automatic check_table(input int base, input string tag);
    int n;
    n = wr_words.size() - base;
    checks++;
    if (n != 11) begin errors++; $display("FAIL %s_strobes got %0d want 11", tag, n); end
    for (int i = 0; i < 11 && i < n; i++) begin
      checks++;
      if (wr_words[base + i] !== exp_word(i)) begin
        errors++; $display("FAIL %s_word%0d got %h want %h", tag, i, wr_words[base + i], exp_word(i));
      end
    end
  endtask

  task automatic test_init_sequence();
    int base;
    bit ok;
    base = wr_words.size();
    pulse_start();
    wait_done(15000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL init_timeout init_done=%b want 1", init_done); end
    repeat (5) @(negedge clk);
    check_table(base, "init");
    for (int i = base + 1; i < wr_words.size(); i++) begin
      checks++;
      if (wr_times[i] - wr_times[i - 1] < MIN_SPACING) begin
        errors++; $display("FAIL spacing%0d got %0d want >=%0d", i - base, wr_times[i] - wr_times[i - 1], MIN_SPACING);
      end
    end
    checks++;
    if (busy !== 1'b0 || init_done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL init_end busy=%b done=%b err=%b want 0 1 0", busy, init_done, err);
    end
    checks++;
    if (cfg_index !== 4'd10) begin errors++; $display("FAIL init_index got %0d want 10", cfg_index); end
  endtask

  task automatic test_start_ignored();
    int base;
    base = wr_words.size();
    @(negedge clk);
    pulse_start();
    repeat (100) @(negedge clk);
    checks++;
    if (wr_words.size() != base || busy !== 1'b0) begin
      errors++; $display("FAIL start_after_done strobes=%0d busy=%b want 0 0", wr_words.size() - base, busy);
    end
  endtask

  task automatic test_host_write();
    int a, d, base, ab;
    bit seen, ok;
    logic [23:0] w;
    for (int it = 0; it < 3; it++) begin
      a = $urandom_range(0, 127);
      d = $urandom_range(0, 511);
      resp_len = $urandom_range(5, 60);
      w = word_of(8'h34, a, d);
      base = wr_words.size();
      ab = ack_cnt;
      host_addr = 7'(a); host_data = 9'(d); host_req = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (host_ack) begin
          seen = 1'b1;
          checks++;
          if (i2c_din !== w || i2c_wr !== 1'b1) begin
            errors++; $display("FAIL host_issue%0d din=%h wr=%b want %h 1", it, i2c_din, i2c_wr, w);
          end
          break;
        end
      end
      host_req = 1'b0;
      checks++;
      if (!seen) begin errors++; $display("FAIL host_ack%0d got 0 want 1", it); end
      wait_not_busy(3000, ok);
      repeat (3) @(negedge clk);
      checks++;
      if (wr_words.size() != base + 1 || ack_cnt != ab + 1) begin
        errors++; $display("FAIL host_count%0d strobes=%0d acks=%0d want 1 1", it, wr_words.size() - base, ack_cnt - ab);
      end else begin
        checks++;
        if (wr_words[base] !== w) begin errors++; $display("FAIL host_word%0d got %h want %h", it, wr_words[base], w); end
      end
      checks++;
      if (cfg_index !== 4'd10 || busy !== 1'b0) begin
        errors++; $display("FAIL host_end%0d index=%0d busy=%b want 10 0", it, cfg_index, busy);
      end
    end
    resp_len = 50;
  endtask

  task automatic test_host_during_init();
    int base, ab;
    bit early, ok, seen;
    apply_reset();
    base = wr_words.size();
    ab = ack_cnt;
    pulse_start();
    host_addr = 7'h02; host_data = 9'h07F; host_req = 1'b1;
    early = 1'b0; ok = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if (host_ack && !init_done) early = 1'b1;
      if (init_done) begin ok = 1'b1; break; end
    end
    checks++;
    if (early || !ok) begin errors++; $display("FAIL host_pending early_ack=%b done=%b want 0 1", early, ok); end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (host_ack) begin seen = 1'b1; break; end
    end
    host_req = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL host_served got 0 want 1"); end
    wait_not_busy(3000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_words.size() != base + 12 || ack_cnt != ab + 1) begin
      errors++; $display("FAIL host_init_count strobes=%0d acks=%0d want 12 1", wr_words.size() - base, ack_cnt - ab);
    end else begin
      checks++;
      if (wr_words[base + 11] !== 24'h34047F) begin
        errors++; $display("FAIL host_init_word got %h want 34047f", wr_words[base + 11]);
      end
    end
  endtask

  task automatic test_timeout();
    int base;
    bit ok;
    apply_reset();
    skip_word = exp_word(3);
    skip_en = 1'b1;
    base = wr_words.size();
    pulse_start();
    wait_word(skip_word, 8000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_entry3 seen=0 want 1"); end
    repeat (15) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_early got %b want 0", err); end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
    repeat ($urandom_range(1, 500)) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL to_busy got %b want 1", busy); end
    pulse_start();
    wait_done(15000, ok);
    repeat (5) @(negedge clk);
    check_table(base, "to");
    checks++;
    if (init_done !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL to_end done=%b err=%b want 1 1", init_done, err);
    end
    skip_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    pulse_start();
    wait_word(exp_word(5), 8000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_entry5 seen=0 want 1"); end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || i2c_idle !== 1'b0) begin
      errors++; $display("FAIL mid_wait_idle busy=%b idle=%b want 1 0", busy, i2c_idle);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({i2c_wr, host_ack, busy, init_done, err} !== 5'b0 || cfg_index !== 4'd0 || i2c_din !== 24'h0) begin
      errors++; $display("FAIL mid_reset flags=%b index=%0d din=%h want 00000 0 000000",
                         {i2c_wr, host_ack, busy, init_done, err}, cfg_index, i2c_din);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100 && !i2c_idle; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || i2c_wr !== 1'b0) begin
      errors++; $display("FAIL mid_after_reset busy=%b wr=%b want 0 0", busy, i2c_wr);
    end
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i2c_wr) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok || i2c_din !== 24'h341E00 || cfg_index !== 4'd0) begin
      errors++; $display("FAIL restart seen=%b din=%h index=%0d want 1 341e00 0", ok, i2c_din, cfg_index);
    end
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_start_ignored();
    test_host_write();
    test_host_during_init();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
